// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, keeps one instruction-memory request in flight and presents fetched words to decode.
// Optional IFETCH_ALIGN_FAULT_EN: misaligned redirect targets raise if_fault instead of being aligned.
module ifetch_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
`ifdef IFETCH_ALIGN_FAULT_EN
  output logic             if_fault,
`endif
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_instr,
  input  logic             id_ready
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP, S_HOLD} state_t;
  localparam logic [WIDTH-1:0] AMASK = ~WIDTH'(3);
  state_t state, state_n;
  logic [WIDTH-1:0] pc, pc_n, req_addr, req_n, if_pc_n, tgt, la;
  logic [31:0] if_instr_n;
  logic if_valid_n, go;
`ifdef IFETCH_ALIGN_FAULT_EN
  logic flt_go;
  assign tgt = redirect_pc;
`else
  assign tgt = redirect_pc & AMASK;
`endif
  assign imem_req = state == S_FETCH || state == S_DROP;
  assign imem_addr = req_addr;
  // "go" launches a fresh request to la; the pending redirect target always lives in pc
  always_comb begin
    state_n = state;
    pc_n = pc;
    req_n = req_addr;
    if_valid_n = if_valid;
    if_pc_n = if_pc;
    if_instr_n = if_instr;
    go = 1'b0;
    la = pc;
    case (state)
      S_IDLE: begin
        go = 1'b1;
        la = redirect ? tgt : pc;
        pc_n = la;
      end
      S_FETCH:
        if (redirect) begin
          pc_n = tgt;
          la = tgt;
          go = imem_ack;
          state_n = imem_ack ? S_FETCH : S_DROP;
        end else if (imem_ack) begin
          if_valid_n = 1'b1;
          if_pc_n = req_addr;
          if_instr_n = imem_rdata;
          pc_n = req_addr + WIDTH'(4);
          state_n = S_HOLD;
        end
      S_DROP: begin
        pc_n = redirect ? tgt : pc;
        la = redirect ? tgt : pc;
        go = imem_ack;
      end
      default:
        if (redirect || id_ready) begin
          if_valid_n = 1'b0;
          pc_n = redirect ? tgt : pc;
          la = redirect ? tgt : pc;
          go = 1'b1;
        end
    endcase
`ifdef IFETCH_ALIGN_FAULT_EN
    flt_go = 1'b0;
`endif
    if (go) begin
      state_n = S_FETCH;
      req_n = la;
`ifdef IFETCH_ALIGN_FAULT_EN
      if (la[1:0] != 2'b00) begin
        flt_go = 1'b1;
        state_n = S_HOLD;
        req_n = req_addr;
        if_valid_n = 1'b1;
        if_pc_n = la;
        if_instr_n = '0;
        pc_n = (la & AMASK) + WIDTH'(4);
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_instr <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_addr <= req_n;
      if_valid <= if_valid_n;
      if_pc <= if_pc_n;
      if_instr <= if_instr_n;
    end
`ifdef IFETCH_ALIGN_FAULT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) if_fault <= 1'b0;
    else if_fault <= state_n == S_HOLD && (flt_go || (state == S_HOLD && if_fault));
`endif
endmodule
